// File: rtl/spi_master_if.sv
// SPI bus bundle for the AES self-test top.
// master/slave are the usual two ends of the link. board is used by spi_master,
// which contains both ends, so it drives all four wires and exposes them for observation.
interface spi_master_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, cs_n, mosi, input miso);
  modport slave  (input sclk, cs_n, mosi, output miso);
  modport board  (output sclk, cs_n, mosi, miso);
endinterface

// File: rtl/spi_master.sv
// AES-over-SPI self-test top.
// After reset it writes {KEY, PLAINTEXT} to the embedded AES slave over mode-0 SPI,
// waits, reads back 128 ciphertext bits, and lights led on an exact match.
module spi_master #(
  parameter int unsigned  CLK_DIV     = 2,
  parameter int unsigned  WAIT_CYCLES = 64,
  parameter logic [127:0] KEY         = 128'h000102030405060708090a0b0c0d0e0f,
  parameter logic [127:0] PLAINTEXT   = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] EXPECTED    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.board  bus,
  output logic         led
);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, TX, GAP, RX, CHECK, DONE} state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [9:0]         half_reg, half_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic [255:0]       shift_reg, shift_next;
  logic               sclk_reg, sclk_next;
  logic               cs_n_reg, cs_n_next;
  logic               led_reg, led_next;
  logic               tick;
  logic [9:0]         half_last;
  logic               miso_in;

  // One tick per SCLK half-period; half_last is the half count at which the trailing gap ends.
  assign tick      = (div_reg == DIV_W'(CLK_DIV - 1));
  assign half_last = (state_reg == TX) ? 10'd512 : 10'd256;
  assign miso_in   = bus.miso;

  assign bus.sclk = sclk_reg;
  assign bus.cs_n = cs_n_reg;
  // The MSB of the shift register is the current bit; MOSI is held low outside the write frame.
  assign bus.mosi = (state_reg == TX) & shift_reg[255];
  assign led      = led_reg;

  // Next-state and datapath: SCLK toggles on every tick; a falling-edge tick shifts
  // the register (TX shifts zeros in, RX shifts MISO in), so MISO is captured at the
  // end of the high phase, after the slave's one-cycle edge detection has settled.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    half_next  = half_reg;
    wait_next  = wait_reg;
    shift_next = shift_reg;
    sclk_next  = sclk_reg;
    cs_n_next  = cs_n_reg;
    led_next   = led_reg;
    case (state_reg)
      IDLE: begin
        shift_next = {KEY, PLAINTEXT};
        cs_n_next  = 1'b0;
        div_next   = '0;
        half_next  = '0;
        state_next = TX;
      end
      TX, RX: begin
        div_next = tick ? '0 : div_reg + DIV_W'(1);
        if (tick) begin
          if (half_reg == half_last) begin
            cs_n_next  = 1'b1;
            half_next  = '0;
            wait_next  = '0;
            state_next = (state_reg == TX) ? GAP : CHECK;
          end else begin
            sclk_next = ~sclk_reg;
            half_next = half_reg + 10'd1;
            if (sclk_reg)
              shift_next = {shift_reg[254:0], (state_reg == RX) ? miso_in : 1'b0};
          end
        end
      end
      GAP: begin
        if (wait_reg == WAIT_W'(WAIT_CYCLES - 1)) begin
          cs_n_next  = 1'b0;
          div_next   = '0;
          half_next  = '0;
          state_next = RX;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end
      CHECK: begin
        led_next   = (shift_reg[127:0] == EXPECTED);
        state_next = DONE;
      end
      DONE: begin
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any frame and returns the bus to idle levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      half_reg  <= '0;
      wait_reg  <= '0;
      shift_reg <= '0;
      sclk_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      led_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      half_reg  <= half_next;
      wait_reg  <= wait_next;
      shift_reg <= shift_next;
      sclk_reg  <= sclk_next;
      cs_n_reg  <= cs_n_next;
      led_reg   <= led_next;
    end
  end

  Slave u_slave (
    .clk  (clk),
    .reset(reset),
    .sclk (bus.sclk),
    .cs_n (bus.cs_n),
    .mosi (bus.mosi),
    .miso (bus.miso)
  );
endmodule

// AES-128 SPI slave: receives {key, plaintext} (256 bits), encrypts with one round
// per clk, then shifts the 128-bit ciphertext out MSB first on the next frame.
module Slave (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso
);
  logic         sclk_d_reg;
  logic [255:0] rx_reg;
  logic [8:0]   rx_cnt_reg;
  logic [127:0] st_reg, rk_reg, tx_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_reg;
  logic         busy_reg;
  logic         rise, fall;
  logic [127:0] rk_next, st_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x, inv;
    x = a;
    for (int i = 0; i < 6; i++) x = gf_mul(gf_mul(x, x), a);
    inv = gf_mul(x, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state is row i%4, column i/4 (byte 0 in the top bits).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[4*c+rw] = b[4*((c+rw)%4)+rw];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (last)
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r ^ rk;
  endfunction

  assign rise    = sclk & ~sclk_d_reg;
  assign fall    = ~sclk & sclk_d_reg;
  assign miso    = tx_reg[127];
  assign rk_next = expand_key(rk_reg, rcon_reg);
  assign st_next = aes_round(st_reg, rk_next, round_reg == 4'd10);

  // Frame reception, cipher start on cs_n rising after a full 256-bit frame, round iteration and readout shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d_reg <= 1'b0;
      rx_reg     <= '0;
      rx_cnt_reg <= '0;
      st_reg     <= '0;
      rk_reg     <= '0;
      tx_reg     <= '0;
      rcon_reg   <= '0;
      round_reg  <= '0;
      busy_reg   <= 1'b0;
    end else begin
      sclk_d_reg <= sclk;
      if (!cs_n) begin
        if (rise) begin
          rx_reg <= {rx_reg[254:0], mosi};
          if (rx_cnt_reg != 9'd256) rx_cnt_reg <= rx_cnt_reg + 9'd1;
        end
        if (fall) tx_reg <= {tx_reg[126:0], 1'b0};
      end else if (rx_cnt_reg == 9'd256) begin
        st_reg     <= rx_reg[127:0] ^ rx_reg[255:128];
        rk_reg     <= rx_reg[255:128];
        rcon_reg   <= 8'h01;
        round_reg  <= 4'd1;
        busy_reg   <= 1'b1;
        rx_cnt_reg <= '0;
      end else begin
        rx_cnt_reg <= '0;
      end
      if (busy_reg) begin
        st_reg    <= st_next;
        rk_reg    <= rk_next;
        rcon_reg  <= xtime(rcon_reg);
        round_reg <= round_reg + 4'd1;
        if (round_reg == 4'd10) begin
          busy_reg <= 1'b0;
          tx_reg   <= st_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: nominal run, bus protocol, mismatch,
// reset after success, reset mid-write-frame, and CLK_DIV sweep.
module tb_spi_master;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  logic led_nom, led_bad, led_d1, led_d5;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [255:0] frame_q[$];
  int           lat_q[$];

  spi_master_if nom_bus();
  spi_master_if bad_bus();
  spi_master_if d1_bus();
  spi_master_if d5_bus();

  spi_master u_nom (.clk(clk), .reset(reset_a), .bus(nom_bus), .led(led_nom));
  spi_master #(.EXPECTED(128'h0)) u_bad (.clk(clk), .reset(reset_b), .bus(bad_bus), .led(led_bad));
  spi_master #(.CLK_DIV(1)) u_d1 (.clk(clk), .reset(reset_b), .bus(d1_bus), .led(led_d1));
  spi_master #(.CLK_DIV(5)) u_d5 (.clk(clk), .reset(reset_b), .bus(d5_bus), .led(led_d5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int val, input int lo, input int hi);
    n_assert++;
    assert (val >= lo && val <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  // Watches the nominal bus for one write+read run; optionally also the mismatch and sweep instances.
  task automatic watch(input bit others, input int budget);
    int start, phase, wrises, wlow, gap, rrises, lat, d1_n, d5_n, d1_lat, d5_lat, exp_lat;
    int d1_r[2];
    int d5_r[2];
    bit prev, d1_prev, d5_prev, rmosi, led_drop, led_early, bad_led;
    logic [255:0] wbits, exp_frame;
    start = cyc; phase = 0; wrises = 0; wlow = 0; gap = 0; rrises = 0; lat = -1;
    d1_n = 0; d5_n = 0; d1_lat = -1; d5_lat = -1; d1_r[0] = 0; d1_r[1] = 0; d5_r[0] = 0; d5_r[1] = 0;
    prev = 0; d1_prev = 0; d5_prev = 0; rmosi = 0; led_drop = 0; led_early = 0; bad_led = 0;
    wbits = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!nom_bus.cs_n) begin
        if (phase == 0) phase = 1;
        else if (phase == 2) phase = 3;
      end else begin
        if (phase == 1) phase = 2;
        else if (phase == 3) phase = 4;
      end
      case (phase)
        1: begin
          wlow++;
          if (nom_bus.sclk && !prev) begin wbits = {wbits[254:0], nom_bus.mosi}; wrises++; end
        end
        2: gap++;
        3: if (nom_bus.sclk && !prev) begin rrises++; rmosi = rmosi | nom_bus.mosi; end
        default: ;
      endcase
      prev = nom_bus.sclk;
      if (led_nom && lat < 0) lat = cyc - start;
      if (!led_nom && lat >= 0) led_drop = 1;
      if (led_nom && phase < 4) led_early = 1;
      if (others) begin
        if (d1_bus.sclk && !d1_prev && d1_n < 2) begin d1_r[d1_n] = cyc; d1_n++; end
        if (d5_bus.sclk && !d5_prev && d5_n < 2) begin d5_r[d5_n] = cyc; d5_n++; end
        d1_prev = d1_bus.sclk;
        d5_prev = d5_bus.sclk;
        if (led_d1 && d1_lat < 0) d1_lat = cyc - start;
        if (led_d5 && d5_lat < 0) d5_lat = cyc - start;
        if (led_bad) bad_led = 1;
      end
    end
    exp_frame = frame_q.pop_front();
    exp_lat   = lat_q.pop_front();
    $display("run: write %0d rises, gap %0d cycles, read %0d rises, led after %0d cycles",
             wrises, gap, rrises, lat);
    chk("write_rises", wrises, 256);
    chk("write_bits", wbits, exp_frame);
    chk("mosi_bits_0_7", wbits[255:248], 8'h00);
    chk("mosi_bits_120_127", wbits[135:128], 8'h0f);
    chk("mosi_bits_128_135", wbits[127:120], 8'h00);
    chk("mosi_last_8", wbits[7:0], 8'hff);
    chk("write_cs_low_cycles", wlow, 1026);
    chk_range("gap_cycles", gap, 64, 100000);
    chk("read_rises", rrises, 128);
    chk("read_mosi_zero", rmosi, 1'b0);
    chk_range("led_latency", lat, exp_lat - 4, exp_lat + 4);
    chk("led_no_drop", led_drop, 1'b0);
    chk("led_not_early", led_early, 1'b0);
    if (others) begin
      $display("sweep: div1 period %0d led %0d, div5 period %0d led %0d; mismatch led seen %0d",
               d1_r[1] - d1_r[0], d1_lat, d5_r[1] - d5_r[0], d5_lat, bad_led);
      chk("div1_period", d1_r[1] - d1_r[0], 2);
      chk("div5_period", d5_r[1] - d5_r[0], 10);
      exp_lat = lat_q.pop_front();
      chk_range("div1_led_latency", d1_lat, exp_lat - 4, exp_lat + 4);
      exp_lat = lat_q.pop_front();
      chk_range("div5_led_latency", d5_lat, exp_lat - 4, exp_lat + 4);
      chk("mismatch_led_never", bad_led, 1'b0);
      chk("mismatch_done_cs_n", bad_bus.cs_n, 1'b1);
      chk("mismatch_done_sclk", bad_bus.sclk, 1'b0);
    end
  endtask

  initial begin
    int rises;
    bit prev;
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_cs_n", nom_bus.cs_n, 1'b1);
    chk("reset_sclk", nom_bus.sclk, 1'b0);
    chk("reset_mosi", nom_bus.mosi, 1'b0);
    chk("reset_led", led_nom, 1'b0);
    chk("reset_led_sweep", {led_bad, led_d1, led_d5}, 3'b000);

    reset_a = 1'b1;
    reset_b = 1'b1;
    frame_q.push_back({KEY_C, PT_C});
    lat_q.push_back(770 * 2 + 66);
    lat_q.push_back(770 * 1 + 66);
    lat_q.push_back(770 * 5 + 66);
    $display("release: nominal, mismatch, CLK_DIV=1 and CLK_DIV=5 instances");
    watch(1'b1, 4100);

    chk("led_before_reset", led_nom, 1'b1);
    #2 reset_a = 1'b0;
    #1 chk("led_async_drop", led_nom, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("led_held_low", led_nom, 1'b0);
    end
    $display("reset after success: led low while reset held");

    @(negedge clk);
    reset_a = 1'b1;
    rises = 0;
    prev = 0;
    for (int i = 0; i < 1200 && rises < 100; i++) begin
      @(negedge clk);
      if (nom_bus.sclk && !prev && !nom_bus.cs_n) rises++;
      prev = nom_bus.sclk;
    end
    chk("abort_reached_bit100", rises, 100);
    reset_a = 1'b0;
    #1;
    chk("abort_cs_n", nom_bus.cs_n, 1'b1);
    chk("abort_sclk", nom_bus.sclk, 1'b0);
    chk("abort_mosi", nom_bus.mosi, 1'b0);
    chk("abort_led", led_nom, 1'b0);
    $display("reset mid-write at bit %0d: bus back to idle", rises);
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    frame_q.push_back({KEY_C, PT_C});
    lat_q.push_back(770 * 2 + 66);
    watch(1'b0, 1700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
